// File: rtl/qdr_lvds_rx.sv
// qdr_lvds_rx: receive side of the QDR LVDS ADC link.
// The lane clock, data lanes and frame marker are brought into the system clock
// domain, one 16-bit word {ovr, spare, data} is rebuilt from four nibbles, and
// a hunt/sync/locked state machine checks the frame marker and a watchdog
// drops the lock on an idle link.

module qdr_lvds_rx #(
   parameter int DATA_W      = 14,
   parameter int LANES       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_FRAMES = 2,
   parameter int TIMEOUT     = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [LANES-1:0]  DA,
   input  logic              DACLK,
   input  logic              DAFRAME,
   output logic [DATA_W-1:0] data_out,
   output logic              ovr_out,
   output logic              data_valid,
   output logic              locked,
   output logic              frame_err,
   output logic [7:0]        err_count
);

   localparam int WORD_W = DATA_W + 2;
   localparam int NSYM   = WORD_W / LANES;
   localparam int IDX_W  = (NSYM > 1) ? $clog2(NSYM) : 1;
   localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
   localparam int WD_W   = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

   logic [SYNC_STAGES-1:0][LANES-1:0] daSync_q;
   logic [SYNC_STAGES-1:0]            clkSync_q;
   logic [SYNC_STAGES-1:0]            frmSync_q;
   logic                              dclk_q;

   state_t              state_q;
   logic [IDX_W-1:0]    idx_q;
   logic [WORD_W-1:0]   word_q;
   logic [GOOD_W-1:0]   goodCnt_q;
   logic [WD_W-1:0]     wdog_q;
   logic [DATA_W-1:0]   data_q;
   logic                ovr_q;
   logic                dataValid_q;
   logic                locked_q;
   logic                frameErr_q;
   logic [7:0]          errCount_q;

   logic [LANES-1:0]    daS;
   logic                frmS;
   logic                symStb;
   logic [WORD_W-1:0]   word_d;
   logic [WORD_W-1:0]   startWord;

   // Synchronizer chains; all three inputs move together so a symbol's data
   // and frame marker line up with its lane-clock edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         daSync_q  <= '0;
         clkSync_q <= '0;
         frmSync_q <= '0;
         dclk_q    <= 1'b0;
      end else begin
         daSync_q[0]  <= DA;
         clkSync_q[0] <= DACLK;
         frmSync_q[0] <= DAFRAME;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            daSync_q[s]  <= daSync_q[s-1];
            clkSync_q[s] <= clkSync_q[s-1];
            frmSync_q[s] <= frmSync_q[s-1];
         end
         dclk_q <= clkSync_q[SYNC_STAGES-1];
      end
   end

   assign daS       = daSync_q[SYNC_STAGES-1];
   assign frmS      = frmSync_q[SYNC_STAGES-1];
   assign symStb    = clkSync_q[SYNC_STAGES-1] ^ dclk_q;
   assign startWord = {daS, {(WORD_W-LANES){1'b0}}};

   // Current word with the incoming nibble dropped into the slot for idx_q.
   always_comb begin
      word_d = word_q;
      for (int k = 0; k < NSYM; k++) begin
         if (idx_q == IDX_W'(k)) begin
            word_d[(NSYM-1-k)*LANES +: LANES] = daS;
         end
      end
   end

   // Framing state machine, watchdog, error counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= HUNT;
         idx_q       <= '0;
         word_q      <= '0;
         goodCnt_q   <= '0;
         wdog_q      <= '0;
         data_q      <= '0;
         ovr_q       <= 1'b0;
         dataValid_q <= 1'b0;
         locked_q    <= 1'b0;
         frameErr_q  <= 1'b0;
         errCount_q  <= '0;
      end else begin
         dataValid_q <= 1'b0;
         frameErr_q  <= 1'b0;

         if (symStb) begin
            wdog_q <= '0;
         end else if (wdog_q != WD_W'(TIMEOUT)) begin
            wdog_q <= wdog_q + 1'b1;
         end

         if (symStb) begin
            if (state_q == HUNT) begin
               if (frmS) begin
                  word_q  <= startWord;
                  idx_q   <= IDX_W'(1);
                  state_q <= SYNC;
               end
            end else if (idx_q == '0) begin
               if (frmS) begin
                  word_q <= startWord;
                  idx_q  <= IDX_W'(1);
               end else begin
                  frameErr_q <= 1'b1;
                  if (errCount_q != 8'hFF) errCount_q <= errCount_q + 1'b1;
                  goodCnt_q  <= '0;
                  locked_q   <= 1'b0;
                  idx_q      <= '0;
                  state_q    <= HUNT;
               end
            end else if (frmS) begin
               // Marker arrived early: treat this symbol as the start of a new frame.
               frameErr_q <= 1'b1;
               if (errCount_q != 8'hFF) errCount_q <= errCount_q + 1'b1;
               goodCnt_q  <= '0;
               locked_q   <= 1'b0;
               word_q     <= startWord;
               idx_q      <= IDX_W'(1);
               state_q    <= SYNC;
            end else begin
               word_q <= word_d;
               if (idx_q == IDX_W'(NSYM-1)) begin
                  idx_q <= '0;
                  if (state_q == LOCKED || goodCnt_q == GOOD_W'(LOCK_FRAMES-1)) begin
                     data_q      <= word_d[DATA_W-1:0];
                     ovr_q       <= word_d[WORD_W-1];
                     dataValid_q <= 1'b1;
                     locked_q    <= 1'b1;
                     state_q     <= LOCKED;
                  end else begin
                     goodCnt_q <= goodCnt_q + 1'b1;
                  end
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
         end else if (wdog_q == WD_W'(TIMEOUT-1) && state_q != HUNT) begin
            state_q   <= HUNT;
            locked_q  <= 1'b0;
            goodCnt_q <= '0;
            idx_q     <= '0;
         end
      end
   end

   assign data_out   = data_q;
   assign ovr_out    = ovr_q;
   assign data_valid = dataValid_q;
   assign locked     = locked_q;
   assign frame_err  = frameErr_q;
   assign err_count  = errCount_q;

endmodule

// File: tb/tb_qdr_lvds_rx.sv
// tb_qdr_lvds_rx: directed bench for qdr_lvds_rx. Serializes words onto the
// lanes with one lane-clock toggle every five system clocks and checks the
// decoded words, lock status, framing errors and watchdog behaviour.

module tb_qdr_lvds_rx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  DA = '0;
   logic        DACLK = 1'b0;
   logic        DAFRAME = 1'b0;
   logic [13:0] data_out;
   logic        ovr_out;
   logic        data_valid;
   logic        locked;
   logic        frame_err;
   logic [7:0]  err_count;

   int total = 0;
   int bad = 0;
   int dvPulses = 0;
   int errPulses = 0;
   logic prevDv = 1'b0;

   typedef struct {
      logic [13:0] data;
      logic        ovr;
      int          nSyms;
      logic        expValid;
      logic        expLocked;
      int          expErr;
      int          expErrCnt;
   } vec_t;

   vec_t vecs[7];

   qdr_lvds_rx dut (
      .clk        (clk),
      .reset      (reset),
      .DA         (DA),
      .DACLK      (DACLK),
      .DAFRAME    (DAFRAME),
      .data_out   (data_out),
      .ovr_out    (ovr_out),
      .data_valid (data_valid),
      .locked     (locked),
      .frame_err  (frame_err),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   // Hard stop in case something stalls the stimulus.
   initial begin
      #2000000;
      $display("[TB] FAIL timeout bench did not finish");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Counts output strobes and checks that data_valid never lasts two cycles.
   always @(negedge clk) begin
      if (data_valid) begin
         dvPulses++;
         checkOutput("dvWidth", {31'd0, prevDv}, 32'd0);
      end
      if (frame_err) errPulses++;
      prevDv = data_valid;
   end

   // One lane-clock toggle; dvSeq holds data_valid on the three following negedges.
   task automatic sendSymbol(input logic [3:0] nib, input logic frm, output logic [2:0] dvSeq);
      @(negedge clk);
      DA      = nib;
      DAFRAME = frm;
      DACLK   = ~DACLK;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         dvSeq[i] = data_valid;
      end
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [13:0] data, input logic ovr, input int nSyms,
                                output logic [2:0] dvSeq);
      logic [15:0] word;
      logic [2:0]  seq;
      word  = {ovr, 1'b0, data};
      dvSeq = '0;
      for (int i = 0; i < nSyms; i++) begin
         sendSymbol(word[15-4*i -: 4], (i == 0), seq);
         if (i == 3) dvSeq = seq;
      end
   endtask

   task automatic runVector(input vec_t v, input string tag);
      int dv0, e0;
      logic [2:0] seq;
      dv0 = dvPulses;
      e0  = errPulses;
      applyStimulus(v.data, v.ovr, v.nSyms, seq);
      checkOutput({tag, " dvCount"}, dvPulses - dv0, v.expValid ? 1 : 0);
      if (v.expValid) begin
         checkOutput({tag, " data"}, {18'd0, data_out}, {18'd0, v.data});
         checkOutput({tag, " ovr"}, {31'd0, ovr_out}, {31'd0, v.ovr});
         checkOutput({tag, " latency"}, {29'd0, seq}, 32'b100);
      end
      checkOutput({tag, " locked"}, {31'd0, locked}, {31'd0, v.expLocked});
      checkOutput({tag, " errStrobes"}, errPulses - e0, v.expErr);
      checkOutput({tag, " errCount"}, {24'd0, err_count}, v.expErrCnt);
   endtask

   initial begin
      logic [2:0] seq;
      int dv0, e0;

      vecs[0] = '{14'h1FFF, 1'b0, 4, 1'b0, 1'b0, 0, 0};
      vecs[1] = '{14'h2000, 1'b1, 4, 1'b1, 1'b1, 0, 0};
      vecs[2] = '{14'h1BC3, 1'b0, 4, 1'b1, 1'b1, 0, 0};
      vecs[3] = '{14'h3A5C, 1'b1, 2, 1'b0, 1'b1, 0, 0};
      vecs[4] = '{14'h0123, 1'b0, 4, 1'b0, 1'b0, 1, 1};
      vecs[5] = '{14'h3FFF, 1'b1, 4, 1'b1, 1'b1, 0, 1};
      vecs[6] = '{14'h0000, 1'b0, 4, 1'b1, 1'b1, 0, 1};

      // Reset and idle state
      reset = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("reset data", {18'd0, data_out}, 32'd0);
      checkOutput("reset ovr", {31'd0, ovr_out}, 32'd0);
      checkOutput("reset locked", {31'd0, locked}, 32'd0);
      checkOutput("reset errCount", {24'd0, err_count}, 32'd0);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("idle dv", dvPulses, 0);
      checkOutput("idle err", errPulses, 0);
      checkOutput("idle locked", {31'd0, locked}, 32'd0);

      // Lock, decode, early-marker error and relock
      for (int i = 0; i < 7; i++) begin
         runVector(vecs[i], $sformatf("vec%0d", i));
      end

      // Idle link: lock drops at the watchdog limit without a framing error
      dv0 = dvPulses;
      e0  = errPulses;
      repeat (55) @(negedge clk);
      checkOutput("wdog stillLocked", {31'd0, locked}, 32'd1);
      repeat (15) @(negedge clk);
      checkOutput("wdog unlocked", {31'd0, locked}, 32'd0);
      checkOutput("wdog noErr", errPulses - e0, 0);
      checkOutput("wdog noDv", dvPulses - dv0, 0);
      runVector('{14'h0AAA, 1'b0, 4, 1'b0, 1'b0, 0, 1}, "relockA");
      runVector('{14'h1555, 1'b1, 4, 1'b1, 1'b1, 0, 1}, "relockB");

      // Reset in the middle of a frame
      dv0 = dvPulses;
      applyStimulus(14'h28B8, 1'b0, 2, seq);
      @(negedge clk);
      reset   = 1'b1;
      DAFRAME = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("midReset noDv", dvPulses - dv0, 0);
      checkOutput("midReset locked", {31'd0, locked}, 32'd0);
      checkOutput("midReset data", {18'd0, data_out}, 32'd0);
      checkOutput("midReset errCount", {24'd0, err_count}, 32'd0);
      runVector('{14'h28B8, 1'b0, 4, 1'b0, 1'b0, 0, 0}, "postReset1");
      runVector('{14'h1234, 1'b1, 4, 1'b1, 1'b1, 0, 0}, "postReset2");

      // 300 forced framing errors saturate the counter
      e0 = errPulses;
      for (int i = 0; i < 301; i++) begin
         sendSymbol(4'hF, 1'b1, seq);
      end
      checkOutput("sat strobes", errPulses - e0, 300);
      checkOutput("sat errCount", {24'd0, err_count}, 32'd255);
      checkOutput("sat locked", {31'd0, locked}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
